// File: rtl/kgp_pc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB control sequencer for the KGP_RISC core.
// Owns PC, IR and the C/Z/S flags; resolves the 3-bit branch code in WB.
module kgp_pc_sequencer #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            imem_valid,
  input  logic [PC_W-1:0] instr_in,
  input  logic [2:0]      branch,
  input  logic            set_flags,
  input  logic            is_halt,
  input  logic            alu_carry,
  input  logic            alu_zero,
  input  logic            alu_sign,
  input  logic [PC_W-1:0] rs_val,
  input  logic [PC_W-1:0] offset,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] ir,
  output logic            imem_req,
  output logic            ir_load,
  output logic            regfile_we,
  output logic [2:0]      state,
  output logic            halted
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t                 st_q, st_d;
  logic [PC_W-1:0]        pc_q, pc_d;
  logic [PC_W-1:0]        ir_q, ir_d;
  logic                   flag_c, flag_z, flag_s;
  logic                   flag_c_d, flag_z_d, flag_s_d;
  logic signed [PC_W-1:0] offset_s;
  logic [PC_W-1:0]        pc_plus4;
  logic [PC_W-1:0]        br_target;

  // Conditional codes 010..111; 000 and 001 never take the relative target.
  function automatic logic branch_taken(input logic [2:0] code, input logic c,
                                        input logic z, input logic s);
    case (code)
      3'b010:  branch_taken = 1'b1;
      3'b011:  branch_taken = s;
      3'b100:  branch_taken = z;
      3'b101:  branch_taken = !z;
      3'b110:  branch_taken = c;
      3'b111:  branch_taken = !c;
      default: branch_taken = 1'b0;
    endcase
  endfunction

  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] a);
    word_align = {a[PC_W-1:2], 2'b00};
  endfunction

  assign offset_s  = offset;
  assign pc_plus4  = pc_q + PC_W'(4);
  assign br_target = pc_plus4 + offset_s;

  always_comb begin
    st_d       = st_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    flag_c_d   = flag_c;
    flag_z_d   = flag_z;
    flag_s_d   = flag_s;
    imem_req   = 1'b0;
    ir_load    = 1'b0;
    regfile_we = 1'b0;
    case (st_q)
      S_IDLE: if (run) st_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) begin
          ir_d    = instr_in;
          ir_load = !rst;
          st_d    = S_DECODE;
        end
      end
      S_DECODE: st_d = is_halt ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (set_flags) begin
          flag_c_d = alu_carry;
          flag_z_d = alu_zero;
          flag_s_d = alu_sign;
        end
        st_d = S_WB;
      end
      S_WB: begin
        regfile_we = 1'b1;
        if (branch == 3'b001)
          pc_d = word_align(rs_val);
        else if (branch_taken(branch, flag_c, flag_z, flag_s))
          pc_d = word_align(br_target);
        else
          pc_d = word_align(pc_plus4);
        st_d = S_FETCH;
      end
      S_HALT:  st_d = S_HALT;
      default: st_d = S_IDLE;
    endcase
  end

  // State boundary: everything advances on the rising edge, reset wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= S_IDLE;
      pc_q   <= RESET_PC;
      ir_q   <= '0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
      flag_s <= 1'b0;
    end else begin
      st_q   <= st_d;
      pc_q   <= pc_d;
      ir_q   <= ir_d;
      flag_c <= flag_c_d;
      flag_z <= flag_z_d;
      flag_s <= flag_s_d;
    end
  end

  assign pc     = pc_q;
  assign ir     = ir_q;
  assign state  = st_q;
  assign halted = (st_q == S_HALT);

endmodule

// File: doc/kgp_pc_sequencer.md
Name: kgp_pc_sequencer

Overview:
- Multi-cycle control sequencer for the KGP_RISC core.
- Owns the program counter and instruction register, and steps the datapath through FETCH/DECODE/EXEC/WB.
- Latches the ALU flags and resolves the 3-bit branch code to select the next PC (PC+4, register target or PC-relative target).
- Sits between instruction memory, the decoder, the ALU and the register file.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_W, 32, PC/instruction/data width.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- run  in  1  start/resume from IDLE
- imem_valid  in  1  instruction memory data valid (handshake for imem_req)
- instr_in  in  PC_W  instruction word from memory
- branch  in  3  decoder branch code for the current IR
- set_flags  in  1  decoder: current instruction updates flags
- is_halt  in  1  decoder: current instruction is HALT
- alu_carry / alu_zero / alu_sign  in  1 each  ALU flags, valid in EXEC
- rs_val  in  PC_W  register rs contents (register-branch target)
- offset  in  PC_W  sign-extended branch offset
- pc  out  PC_W  current PC
- ir  out  PC_W  instruction register
- imem_req  out  1  instruction fetch request
- ir_load  out  1  IR load strobe
- regfile_we  out  1  register-file write enable
- state  out  3  FSM state
- halted  out  1  core halted

Behaviour:
- Reset is synchronous on the rising edge of clk, active-high. Reset values: pc=RESET_PC, ir=0, internal flags C/Z/S=0, state=IDLE, all strobes 0, halted=0.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5. Codes 6 and 7 go to IDLE on the next edge.
- IDLE: outputs quiet. When run=1, go to FETCH.
- FETCH: imem_req=1 (Moore output) every cycle in this state.
  - imem_valid=0: stay in FETCH; pc and ir hold.
  - imem_valid=1: ir<=instr_in, ir_load=1 for that cycle, next state DECODE.
  - imem_valid while not in FETCH is ignored.
- DECODE: one cycle.
  - is_halt=1: next state HALT, halted=1 from the next cycle.
  - Otherwise: next state EXEC.
- EXEC: one cycle. If set_flags=1, C/Z/S <= alu_carry/alu_zero/alu_sign. Otherwise the flags hold.
- WB: one cycle, regfile_we=1. Branch codes 2..7 use the flags as they stand after EXEC. pc is updated per branch, then next state FETCH.
  - 000: pc+4
  - 001: rs_val
  - 010: pc+4+offset (unconditional)
  - 011: S ? pc+4+offset : pc+4
  - 100: Z ? target : pc+4
  - 101: !Z ? target : pc+4
  - 110: C ? target : pc+4
  - 111: !C ? target : pc+4
  - "target" means pc+4+offset.
- Arithmetic: all additions are modulo 2^PC_W with no overflow detection. The new pc has bits [1:0] forced to 00 (word alignment).
- HALT: absorbing state; pc and ir hold, halted=1. Only rst exits HALT.
- A run deassert mid-instruction has no effect. run is sampled only in IDLE.
- rst in any state, including FETCH with imem_valid=1 on the same edge, wins: IR is not loaded and the reset values apply.
- Throughput: 4 cycles per instruction with zero wait states, plus the wait cycles spent in FETCH.

Test Plan:
1. Reset, then run=1 and imem_valid=1 every FETCH, branch=000 for three instructions -> pc goes 0, 4, 8, 0xC; regfile_we pulses once per 4 cycles.
2. set_flags=1 with alu_sign=1 and alu_zero=0 in EXEC, branch=011, pc=0x4, offset=0x880 -> pc=0x888 after WB. Repeat with alu_sign=0 -> pc=0x8.
3. branch=001, rs_val=0x0000_1237 -> pc=0x1234 (low bits cleared). branch=010, pc=0xFFFF_FFFC, offset=0 -> pc wraps to 0x0000_0000.
4. Hold imem_valid=0 for 5 cycles in FETCH, then instr_in=0x0003_0005 with imem_valid=1 -> imem_req high for all 6 cycles, ir=0x0003_0005, ir_load high for exactly 1 cycle.
5. Flag persistence: instruction A has set_flags=1 with alu_carry=1; instruction B has set_flags=0 and branch=110 -> B takes the branch using the carry latched by A.
6. is_halt=1 in DECODE -> state=HALT, halted=1, and run/imem_valid toggling causes no pc change. Assert rst for 1 cycle -> pc=RESET_PC, state=IDLE, halted=0. Assert rst in FETCH together with imem_valid=1 -> ir stays 0.
